maze_search_engine: RTL and testbench

- Depth-first maze solver datapath; the responder to the top-level maze controller, producing the done/fail status that controller consumes.
- Walks an N x N wall map from cell (0,0) to cell (N-1,N-1) through a synchronous-read map memory.
- Keeps the successful path as a direction stack that the replay/run logic can read back.

---
 rtl/maze_pkg.sv | 23 ++
 rtl/maze_search_engine_if.sv | 28 ++
 rtl/maze_search_engine_dir_stack.sv | 31 +++
 rtl/maze_search_engine.sv | 109 ++++++++++
 tb/tb_maze_search_engine.sv | 137 +++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared types and helpers for the maze search engine
// Contents: dir_t move directions, state_t search states, step_t neighbour result,
//           opposite() reverse direction, step() neighbour coordinates plus bounds flag.
package maze_pkg;
   typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;
   typedef enum logic [2:0] {IDLE, CHECK, READ, EVAL, BACK, DONE, FAIL} state_t;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] c;
      logic       oob;
   } step_t;
   function automatic dir_t opposite(dir_t d);
      return dir_t'(d ^ 2'd2);
   endfunction
   // last is N-1; coordinates are carried at the widest supported size (N = 16)
   function automatic step_t step(logic [3:0] r, logic [3:0] c, dir_t d, logic [3:0] last);
      step_t s;
      s.oob = d == UP ? r == 4'd0 : d == RIGHT ? c == last : d == DOWN ? r == last : c == 4'd0;
      s.r   = d == UP ? r - 4'd1 : d == DOWN ? r + 4'd1 : r;
      s.c   = d == LEFT ? c - 4'd1 : d == RIGHT ? c + 4'd1 : c;
      return s;
   endfunction
endpackage

// File: rtl/maze_search_engine_if.sv
// maze_if: controller/memory <-> search engine signal bundle
// Signals: go start pulse, map_addr/map_rd/map_data wall-map read, busy/done_o/fail_o status,
//          path_len/path_idx/path_dir path readout, steps (only with SEARCH_STATS_EN).
// master = controller side, slave = engine side.
interface maze_if #(parameter int N = 16, parameter int AW = $clog2(N), parameter int SD = N * N);
   logic                    go;
   logic [2*AW-1:0]         map_addr;
   logic                    map_rd;
   logic                    map_data;
   logic                    busy;
   logic                    done_o;
   logic                    fail_o;
   logic [$clog2(SD+1)-1:0] path_len;
   logic [$clog2(SD)-1:0]   path_idx;
   logic [1:0]              path_dir;
`ifdef SEARCH_STATS_EN
   logic [15:0]             steps;
   modport master(output go, map_data, path_idx,
                  input map_addr, map_rd, busy, done_o, fail_o, path_len, path_dir, steps);
   modport slave(input go, map_data, path_idx,
                 output map_addr, map_rd, busy, done_o, fail_o, path_len, path_dir, steps);
`else
   modport master(output go, map_data, path_idx,
                  input map_addr, map_rd, busy, done_o, fail_o, path_len, path_dir);
   modport slave(input go, map_data, path_idx,
                 output map_addr, map_rd, busy, done_o, fail_o, path_len, path_dir);
`endif
endinterface

// File: rtl/maze_search_engine_dir_stack.sv
// dir_stack: SD-entry direction stack with combinational random-read port
// Ports: clk, rst; clr empties the stack; push/din write on top; pop drops top;
//        count entries held, top current top entry, rd_idx/rd_dir readout (0 beyond count).
module dir_stack
   import maze_pkg::*;
#(
   parameter int SD = 256,
   parameter int CW = $clog2(SD + 1),
   parameter int IW = $clog2(SD)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  dir_t          din,
   output logic [CW-1:0] count,
   output dir_t          top,
   input  logic [IW-1:0] rd_idx,
   output dir_t          rd_dir
);
   dir_t mem [SD];
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (push) count <= count + 1'b1;
      else if (pop) count <= count - 1'b1;
   always_ff @(posedge clk)
      if (push) mem[IW'(count)] <= din;
   assign top    = mem[IW'(count - 1'b1)];
   assign rd_dir = CW'(rd_idx) < count ? mem[rd_idx] : UP;
endmodule

// File: rtl/maze_search_engine.sv
// maze_search_engine: depth-first maze solver from (0,0) to (N-1,N-1)
// Ports: clk, rst (sync, active high); m (maze_if.slave) carrying go, wall-map read
//        (map_addr, map_rd, map_data one cycle later), busy/done_o/fail_o, path readout,
//        and steps (push+pop count) when SEARCH_STATS_EN is defined.
module maze_search_engine
   import maze_pkg::*;
#(
   parameter int N  = 16,
   parameter int AW = $clog2(N),
   parameter int SD = N * N
) (
   input logic   clk,
   input logic   rst,
   maze_if.slave m
);
   localparam int CW = $clog2(SD + 1);
   state_t          state, nxt;
   logic [AW-1:0]   r, c;
   logic [2:0]      d;
   logic [N*N-1:0]  vis;
   logic [CW-1:0]   len;
   dir_t            top, sd;
   step_t           nb;
   logic [2*AW-1:0] na;
   logic            start, goal, bad, push, pop;
   // one neighbour calculator: trial direction while searching, reverse of top when backing up
   assign sd    = state == BACK ? opposite(top) : dir_t'(d[1:0]);
   assign nb    = step(4'(r), 4'(c), sd, 4'(N - 1));
   assign na    = {nb.r[AW-1:0], nb.c[AW-1:0]};
   assign bad   = nb.oob || |(nb.r >> AW) || |(nb.c >> AW) || vis[na];
   assign start = m.go && (state == IDLE || state == DONE || state == FAIL);
   assign goal  = r == AW'(N - 1) && c == AW'(N - 1);
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt  = state;
      push = 1'b0;
      pop  = 1'b0;
      case (state)
         CHECK: nxt = goal ? DONE : d[2] ? BACK : bad ? CHECK : READ;
         READ:  nxt = EVAL;
         EVAL: begin
            nxt  = CHECK;
            push = !m.map_data;
         end
         BACK: begin
            nxt = len == '0 ? FAIL : CHECK;
            pop = len != '0;
         end
         default: nxt = start ? CHECK : state;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         r   <= '0;
         c   <= '0;
         d   <= '0;
         vis <= '0;
      end else if (start) begin
         r   <= '0;
         c   <= '0;
         d   <= '0;
         vis <= (N*N)'(1);
      end else
         case (state)
            CHECK: if (!goal && !d[2] && bad) d <= d + 3'd1;
            EVAL:
               if (m.map_data) d <= d + 3'd1;
               else begin
                  r       <= nb.r[AW-1:0];
                  c       <= nb.c[AW-1:0];
                  vis[na] <= 1'b1;
                  d       <= '0;
               end
            BACK:
               if (len != '0) begin
                  r <= nb.r[AW-1:0];
                  c <= nb.c[AW-1:0];
                  d <= {1'b0, top} + 3'd1;
               end
            default: ;
         endcase
   dir_stack #(.SD(SD)) u_stack (
      .clk    (clk),
      .rst    (rst),
      .clr    (start),
      .push   (push),
      .pop    (pop),
      .din    (dir_t'(d[1:0])),
      .count  (len),
      .top    (top),
      .rd_idx (m.path_idx),
      .rd_dir (m.path_dir)
   );
   assign m.path_len = len;
   assign m.busy     = state == CHECK || state == READ || state == EVAL || state == BACK;
   assign m.done_o   = state == DONE;
   assign m.fail_o   = state == FAIL;
   assign m.map_rd   = state == READ;
   assign m.map_addr = state == READ ? na : '0;
`ifdef SEARCH_STATS_EN
   logic [15:0] steps;
   always_ff @(posedge clk)
      if (rst || start) steps <= '0;
      else if ((push || pop) && steps != 16'hFFFF) steps <= steps + 16'd1;
   assign m.steps = steps;
`endif
endmodule

// File: tb/tb_maze_search_engine.sv
// tb_maze_search_engine: directed table-driven bench for maze_search_engine at N = 4
module tb_maze_search_engine;
   import maze_pkg::*;
   localparam int N = 4;
   typedef struct {
      string      name;
      logic [15:0] map;
      logic       done;
      logic       fail;
      int         len;
      logic [1:0] path [6];
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] map_bits = '0;
   int          errs = 0;
   int          checks = 0;
   vec_t        vecs [3];
   always #5 clk = ~clk;
   maze_if #(.N(N)) m ();
   maze_search_engine #(.N(N)) dut (.clk(clk), .rst(rst), .m(m));
   always @(posedge clk) m.map_data <= map_bits[m.map_addr];
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   task automatic go_pulse();
      m.go = 1'b1;
      @(negedge clk);
      m.go = 1'b0;
   endtask
   task automatic wait_end(string name);
      bit ok = 0;
      for (int i = 0; i < 1000; i++) begin
         if (m.done_o || m.fail_o) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk({name, " finished"}, 32'(ok), 1);
   endtask
   task automatic check_path(string name, int len, logic [1:0] p [6]);
      for (int i = 0; i < len; i++) begin
         m.path_idx = 4'(i);
         #1;
         chk($sformatf("%s dir[%0d]", name, i), 32'(m.path_dir), 32'(p[i]));
      end
      m.path_idx = 4'(len);
      #1;
      chk($sformatf("%s dir beyond len", name), 32'(m.path_dir), 0);
   endtask
   task automatic replay(string name, int len);
      int r = 0, c = 0;
      bit hit = 0;
      for (int i = 0; i < len; i++) begin
         m.path_idx = 4'(i);
         #1;
         case (m.path_dir)
            2'd0: r--;
            2'd1: c++;
            2'd2: r++;
            default: c--;
         endcase
         if (r < 0 || r >= N || c < 0 || c >= N || map_bits[r*N+c]) hit = 1;
      end
      chk({name, " replay clean"}, 32'(hit), 0);
      chk({name, " replay end"}, 32'(r * N + c), 15);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      vecs[0] = '{"open", 16'h0000, 1'b1, 1'b0, 6, '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2}};
      vecs[1] = '{"boxed", 16'h0012, 1'b0, 1'b1, 0, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
      vecs[2] = '{"deadend", 16'h0880, 1'b1, 1'b0, 6, '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1}};
      m.go = 1'b0;
      m.path_idx = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(m.busy), 0);
      chk("reset done", 32'(m.done_o), 0);
      chk("reset fail", 32'(m.fail_o), 0);
      chk("reset len", 32'(m.path_len), 0);
      chk("reset map_rd", 32'(m.map_rd), 0);
      chk("reset map_addr", 32'(m.map_addr), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
         map_bits = vecs[v].map;
         go_pulse();
         chk({vecs[v].name, " busy"}, 32'(m.busy), 1);
         wait_end(vecs[v].name);
         chk({vecs[v].name, " done"}, 32'(m.done_o), 32'(vecs[v].done));
         chk({vecs[v].name, " fail"}, 32'(m.fail_o), 32'(vecs[v].fail));
         chk({vecs[v].name, " busy end"}, 32'(m.busy), 0);
         chk({vecs[v].name, " len"}, 32'(m.path_len), 32'(vecs[v].len));
         check_path(vecs[v].name, vecs[v].len, vecs[v].path);
         if (vecs[v].done) replay(vecs[v].name, vecs[v].len);
      end
      go_pulse();
      chk("restart done drop", 32'(m.done_o), 0);
      chk("restart busy", 32'(m.busy), 1);
      wait_end("restart");
      chk("restart done", 32'(m.done_o), 1);
      chk("restart len", 32'(m.path_len), 6);
      check_path("restart", 6, vecs[2].path);
      map_bits = 16'h0000;
      go_pulse();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", 32'(m.busy), 0);
      chk("midrst done", 32'(m.done_o), 0);
      chk("midrst fail", 32'(m.fail_o), 0);
      chk("midrst len", 32'(m.path_len), 0);
      rst = 1'b0;
      @(negedge clk);
      go_pulse();
      wait_end("after rst");
      chk("after rst done", 32'(m.done_o), 1);
      chk("after rst len", 32'(m.path_len), 6);
      check_path("after rst", 6, vecs[0].path);
`ifdef SEARCH_STATS_EN
      chk("steps at done", 32'(m.steps), 6);
      repeat (10) @(negedge clk);
      chk("steps frozen", 32'(m.steps), 6);
      chk("done held", 32'(m.done_o), 1);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
